// File: rtl/weight_loader.sv
// Weight loader: fetches one 5x5/4x4/4x2 kernel plus its bias byte from the weight SRAM
// and replays each returned byte as a one-cycle strobe for the EPU weight buffer.
module weight_loader #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_ready,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_weight_new,
    output logic              o_weight_new_16,
    output logic              o_weight_new_8,
    output logic [7:0]        o_weight,
    output logic              o_bias_new,
    output logic [7:0]        o_bias,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [4:0]        issue_q, issue_d;
    logic [4:0]        ret_q, ret_d;
    logic              pend_q, pend_d;
    logic              wn_q, wn_d;
    logic              wn16_q, wn16_d;
    logic              wn8_q, wn8_d;
    logic              bn_q, bn_d;
    logic [7:0]        weight_q, weight_d;
    logic [7:0]        bias_q, bias_d;
    logic              err_q, err_d;

    logic [4:0] n_bytes;
    logic [4:0] r_total;
    logic       issue_active;
    logic       accept;
    logic       start_ok;
    logic       start_bad;

    function automatic logic [4:0] weights_of_mode(input logic [1:0] m);
        case (m)
            2'b00:   return 5'd25;
            2'b01:   return 5'd16;
            2'b10:   return 5'd8;
            default: return 5'd0;
        endcase
    endfunction

    assign n_bytes      = weights_of_mode(mode_q);
    assign r_total      = n_bytes + 5'd1;
    assign issue_active = (state_q == S_FETCH) && (issue_q < r_total);
    assign accept       = issue_active && i_mem_ready;
    assign start_ok     = (state_q == S_IDLE) && i_start && (i_mode != 2'b11);
    assign start_bad    = (state_q == S_IDLE) && i_start && (i_mode == 2'b11);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the load ends once the bias strobe has been presented
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_FETCH;
            S_FETCH: if (bn_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_mem_re   = issue_active;
        o_mem_addr = base_q + ADDR_W'(issue_q);
        o_busy     = (state_q != S_IDLE);
        o_done     = (state_q == S_DONE);
    end

    assign o_weight_new    = wn_q;
    assign o_weight_new_16 = wn16_q;
    assign o_weight_new_8  = wn8_q;
    assign o_weight        = weight_q;
    assign o_bias_new      = bn_q;
    assign o_bias          = bias_q;
    assign o_err           = err_q;

    // Datapath: pend_q marks that i_mem_rdata carries the return of last cycle's read
    always_comb begin
        mode_d   = mode_q;
        base_d   = base_q;
        issue_d  = issue_q;
        ret_d    = ret_q;
        pend_d   = accept;
        wn_d     = 1'b0;
        wn16_d   = 1'b0;
        wn8_d    = 1'b0;
        bn_d     = 1'b0;
        weight_d = weight_q;
        bias_d   = bias_q;
        err_d    = start_bad;

        if (start_ok) begin
            mode_d  = i_mode;
            base_d  = i_base_addr;
            issue_d = 5'd0;
            ret_d   = 5'd0;
        end

        if (accept) begin
            issue_d = issue_q + 5'd1;
        end

        if (pend_q) begin
            ret_d = ret_q + 5'd1;
            if (ret_q < n_bytes) begin
                weight_d = i_mem_rdata;
                case (mode_q)
                    2'b00:   wn_d   = 1'b1;
                    2'b01:   wn16_d = 1'b1;
                    default: wn8_d  = 1'b1;
                endcase
            end else begin
                bn_d   = 1'b1;
                bias_d = i_mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 2'b00;
            base_q   <= '0;
            issue_q  <= 5'd0;
            ret_q    <= 5'd0;
            pend_q   <= 1'b0;
            wn_q     <= 1'b0;
            wn16_q   <= 1'b0;
            wn8_q    <= 1'b0;
            bn_q     <= 1'b0;
            weight_q <= 8'h00;
            bias_q   <= 8'h00;
            err_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            base_q   <= base_d;
            issue_q  <= issue_d;
            ret_q    <= ret_d;
            pend_q   <= pend_d;
            wn_q     <= wn_d;
            wn16_q   <= wn16_d;
            wn8_q    <= wn8_d;
            bn_q     <= bn_d;
            weight_q <= weight_d;
            bias_q   <= bias_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: SRAM model, negedge monitor, and immediate-assertion
// checks of strobe order, data, timing, stalls, wrap, illegal mode, restart and reset.
module tb_weight_loader;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [1:0]  i_mode;
    logic [11:0] i_base_addr;
    logic        o_mem_re;
    logic [11:0] o_mem_addr;
    logic        i_mem_ready;
    logic [7:0]  i_mem_rdata;
    logic        o_weight_new;
    logic        o_weight_new_16;
    logic        o_weight_new_8;
    logic [7:0]  o_weight;
    logic        o_bias_new;
    logic [7:0]  o_bias;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    weight_loader #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode),
        .i_base_addr(i_base_addr), .o_mem_re(o_mem_re), .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
        .o_weight_new(o_weight_new), .o_weight_new_16(o_weight_new_16),
        .o_weight_new_8(o_weight_new_8), .o_weight(o_weight),
        .o_bias_new(o_bias_new), .o_bias(o_bias), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] memf(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], 4'h3};
    endfunction

    // SRAM model: data valid the cycle after an accepted read
    always @(posedge clk) begin
        if (o_mem_re && i_mem_ready) i_mem_rdata <= memf(o_mem_addr);
        else                         i_mem_rdata <= 8'h00;
    end

    // scoreboard state
    logic [11:0] exp_q[$];
    logic [9:0]  obs_q[$];
    logic [11:0] acc_q[$];
    logic [9:0]  exp_s_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int t0 = 0;
    int acc_first, acc_last, w_first, w_last, bias_cyc, done_cyc, err_cyc;
    int done_cnt, err_cnt, busy_cnt, busy_first, busy_last, multi, stall_viol;
    logic        prev_stall;
    logic [11:0] prev_addr;

    task automatic clear_mon();
        obs_q.delete(); acc_q.delete();
        acc_first = -1; acc_last = -1; w_first = -1; w_last = -1;
        bias_cyc = -1; done_cyc = -1; err_cyc = -1;
        done_cnt = 0; err_cnt = 0; busy_cnt = 0; busy_first = -1; busy_last = -1;
        multi = 0; stall_viol = 0; prev_stall = 1'b0; prev_addr = '0;
    endtask

    always @(negedge clk) begin
        int rel;
        int nstb;
        rel = cyc - t0;
        if (o_mem_re && i_mem_ready) begin
            acc_q.push_back(o_mem_addr);
            if (acc_first < 0) acc_first = rel;
            acc_last = rel;
        end
        if (prev_stall && (!o_mem_re || o_mem_addr !== prev_addr)) stall_viol++;
        prev_stall = o_mem_re && !i_mem_ready;
        prev_addr  = o_mem_addr;
        nstb = int'(o_weight_new) + int'(o_weight_new_16) + int'(o_weight_new_8) + int'(o_bias_new);
        if (nstb > 1) multi++;
        if (o_weight_new || o_weight_new_16 || o_weight_new_8) begin
            obs_q.push_back({o_weight_new_8 ? 2'd3 : (o_weight_new_16 ? 2'd2 : 2'd1), o_weight});
            if (w_first < 0) w_first = rel;
            w_last = rel;
        end
        if (o_bias_new) begin
            obs_q.push_back({2'd0, o_bias});
            bias_cyc = rel;
        end
        if (o_done) begin done_cnt++; done_cyc = rel; end
        if (o_err)  begin err_cnt++;  err_cyc  = rel; end
        if (o_busy) begin
            busy_cnt++;
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] out_vec();
        return {o_mem_re, o_mem_addr, o_weight_new, o_weight_new_16, o_weight_new_8,
                o_weight, o_bias_new, o_bias, o_busy, o_done, o_err};
    endfunction

    // driver: start in cycle 0, optionally toggle ready and retrigger start
    task automatic run_load(input logic [1:0] mode, input logic [11:0] base,
                            input bit toggle, input int restart_at, input int limit);
        clear_mon();
        @(posedge clk); #1;
        t0 = cyc; i_mode = mode; i_base_addr = base; i_start = 1'b1; i_mem_ready = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_mode = mode ^ 2'b01; i_base_addr = 12'hABC;
        while (done_cnt == 0 && (cyc - t0) < limit) begin
            @(posedge clk); #1;
            if (toggle) i_mem_ready = ~i_mem_ready;
            i_start = ((cyc - t0) == restart_at);
        end
        i_start = 1'b0; i_mem_ready = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // expected strobe stream and address list for a load of n weights
    task automatic check_stream(input string tag, input logic [1:0] kind, input logic [11:0] base,
                                input int n);
        logic [11:0] a;
        exp_s_q.delete(); exp_q.delete();
        for (int i = 0; i <= n; i++) begin
            a = base + 12'(i);
            exp_q.push_back(a);
            exp_s_q.push_back({(i < n) ? kind : 2'd0, memf(a)});
        end
        chk({tag, "_nstrobes"}, obs_q.size(), exp_s_q.size());
        chk({tag, "_naddr"}, acc_q.size(), exp_q.size());
        for (int i = 0; i < exp_s_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_s_q[i]) chk({tag, "_strobe"}, obs_q[i], exp_s_q[i]);
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) chk({tag, "_addr"}, acc_q[i], exp_q[i]);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_multi"}, multi, 0);
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_mode = 2'b00; i_base_addr = '0; i_mem_ready = 1'b1;
        clear_mon();
        repeat (2) @(negedge clk);
        chk("reset_outputs", out_vec(), 36'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 5x5 at 0x010, full-rate
        run_load(2'b00, 12'h010, 1'b0, -1, 60);
        check_stream("k5", 2'd1, 12'h010, 25);
        chk("k5_acc_first", acc_first, 1);
        chk("k5_acc_last", acc_last, 26);
        chk("k5_w_first", w_first, 3);
        chk("k5_w_last", w_last, 27);
        chk("k5_bias_cyc", bias_cyc, 28);
        chk("k5_done_cyc", done_cyc, 29);
        chk("k5_busy_first", busy_first, 1);
        chk("k5_busy_last", busy_last, 29);
        chk("k5_busy_cnt", busy_cnt, 29);
        chk("k5_hold_weight", o_weight, memf(12'h028));
        chk("k5_hold_bias", o_bias, memf(12'h029));

        // 4x2 at 0x100 with ready toggling
        run_load(2'b10, 12'h100, 1'b1, -1, 80);
        check_stream("k2", 2'd3, 12'h100, 8);
        chk("k2_stall_viol", stall_viol, 0);
        chk("k2_acc_last", acc_last, 17);

        // 4x4 wrapping past the top of memory
        run_load(2'b01, 12'hFF8, 1'b0, -1, 60);
        check_stream("k4", 2'd2, 12'hFF8, 16);
        chk("k4_bias", o_bias, memf(12'h008));

        // illegal mode
        run_load(2'b11, 12'h200, 1'b0, -1, 6);
        chk("err_cnt", err_cnt, 1);
        chk("err_cyc", err_cyc, 1);
        chk("err_no_re", acc_q.size(), 0);
        chk("err_busy", busy_cnt, 0);
        chk("err_no_done", done_cnt, 0);

        // second start mid-load is ignored
        run_load(2'b00, 12'h040, 1'b0, 5, 60);
        check_stream("restart", 2'd1, 12'h040, 25);
        chk("restart_err", err_cnt, 0);

        // reset during cycle 10 of a 5x5 load
        clear_mon();
        @(posedge clk); #1;
        t0 = cyc; i_mode = 2'b00; i_base_addr = 12'h300; i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        while ((cyc - t0) < 10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", out_vec(), 36'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        clear_mon();
        repeat (40) @(posedge clk);
        chk("midreset_no_strobes", obs_q.size(), 0);
        chk("midreset_no_done", done_cnt, 0);
        chk("midreset_no_re", acc_q.size(), 0);

        run_load(2'b00, 12'h300, 1'b0, -1, 60);
        check_stream("postreset", 2'd1, 12'h300, 25);
        chk("postreset_done_cyc", done_cyc, 29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
